seg_data_gen: RTL and testbench



---
 rtl/seg_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/seg_data_gen.sv | 104 ++++++++++
 tb/tb_seg_data_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment data path.
//   BCD_W      - bits per BCD digit
//   BCD_MAX    - largest legal digit value
//   DIGITS_DEF - default digit count for seg_data_gen
//   bcd_t      - one BCD digit
//   bcd_next() - next value of one decade given clear and carry-in
package seg_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned DIGITS_DEF = 6;

  typedef logic [BCD_W-1:0] bcd_t;

  // Clear wins over carry; a carried 9 rolls to 0.
  function automatic bcd_t bcd_next(input bcd_t cur, input logic clr, input logic carry_in);
    bcd_t nxt;
    if (clr) begin
      nxt = '0;
    end else if (carry_in) begin
      nxt = (cur == BCD_MAX) ? bcd_t'(0) : bcd_t'(cur + 4'd1);
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade (0..9) counter stage of the display counter.
// Ports:
//   clk       in  system clock
//   rstn      in  asynchronous active-low reset, digit -> 0
//   clr       in  synchronous clear, overrides carry_in
//   carry_in  in  increment request from the lower stage (or the tick)
//   digit     out current digit value
//   carry_out out carry_in & (digit == 9), feeds the next stage
module bcd_digit
  import seg_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic carry_in,
  output bcd_t digit,
  output logic carry_out
);

  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = bcd_next(digit_q, clr, carry_in);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = carry_in & (digit_q == BCD_MAX);

endmodule

// File: rtl/seg_data_gen.sv
// seg_data_gen: display data source for the dynamic seven-segment path.
// Advances a DIGITS-wide BCD counter once per flag tick (wraps all-nines -> 0).
// Parameters:
//   DIGITS     - number of BCD digits (1..8), digit 0 least significant
//   POINT_MASK - static decimal-point pattern, bit i = point after digit i
// Ports:
//   clk        in  system clock
//   rstn       in  asynchronous active-low reset
//   flag       in  one-cycle increment tick
//   clr        in  synchronous clear (wins over flag)
//   bcd_data   out packed digits, digit i at [4i+3:4i]
//   point      out registered copy of POINT_MASK (0 in reset)
//   seg_en     out display enable, 1 from the first edge after reset
//   digit_mask out per-digit enable
// Build option: define SEG_DATA_LZB_EN to enable leading-zero blanking on
// digit_mask; otherwise digit_mask is constant all ones.
module seg_data_gen
  import seg_pkg::*;
#(
  parameter int unsigned       DIGITS     = DIGITS_DEF,
  parameter logic [DIGITS-1:0] POINT_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flag,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd_data,
  output logic [DIGITS-1:0]     point,
  output logic                  seg_en,
  output logic [DIGITS-1:0]     digit_mask
);

  logic [DIGITS-1:0] carry_in;
  logic [DIGITS-1:0] carry_out;
  logic              wrap_unused;

  assign carry_in[0] = flag;
  // Wrap is silent; the top carry goes nowhere.
  assign wrap_unused = carry_out[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign carry_in[i] = carry_out[i-1];
    end
    bcd_digit u_digit (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .carry_in  (carry_in[i]),
      .digit     (bcd_data[4*i +: 4]),
      .carry_out (carry_out[i])
    );
  end

  logic              seg_en_q;
  logic [DIGITS-1:0] point_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_en_q <= 1'b0;
      point_q  <= '0;
    end else begin
      seg_en_q <= 1'b1;
      point_q  <= POINT_MASK;
    end
  end

  assign seg_en = seg_en_q;
  assign point  = point_q;

`ifdef SEG_DATA_LZB_EN
  // Mask is derived from the next-state digits so it registers on the same
  // edge as the digits themselves and is never a cycle stale.
  logic [4*DIGITS-1:0] bcd_nxt;
  logic [DIGITS-1:0]   mask_d, mask_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_next
    assign bcd_nxt[4*i +: 4] = bcd_next(bcd_data[4*i +: 4], clr, carry_in[i]);
  end

  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    mask_d   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_above  = nz_above | (bcd_nxt[4*i +: 4] != 4'd0);
      mask_d[i] = nz_above | (i == 0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign digit_mask = mask_q;
`else
  assign digit_mask = '1;
`endif

endmodule

// File: tb/tb_seg_data_gen.sv
// Directed bench for seg_data_gen: a 6-digit instance (main checks) and a
// 2-digit instance (all-nines wrap reached in 100 ticks).
module tb_seg_data_gen;

`ifdef SEG_DATA_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        flag, clr, flag_b, clr_b;
  logic [23:0] bcd_data;
  logic [5:0]  point, digit_mask;
  logic        seg_en;
  logic [7:0]  bcd_b;
  logic [1:0]  point_b, mask_b;
  logic        seg_en_b;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #10 clk = ~clk;

  seg_data_gen #(.DIGITS(6), .POINT_MASK(6'b000100)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flag       (flag),
    .clr        (clr),
    .bcd_data   (bcd_data),
    .point      (point),
    .seg_en     (seg_en),
    .digit_mask (digit_mask)
  );

  seg_data_gen #(.DIGITS(2), .POINT_MASK(2'b01)) dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .flag       (flag_b),
    .clr        (clr_b),
    .bcd_data   (bcd_b),
    .point      (point_b),
    .seg_en     (seg_en_b),
    .digit_mask (mask_b)
  );

  // Expected digit_mask: blanking value in the LZB build, all ones otherwise.
  function automatic logic [5:0] m6(input logic [5:0] lzb);
    return LZB ? lzb : 6'h3f;
  endfunction

  function automatic logic [1:0] m2(input logic [1:0] lzb);
    return LZB ? lzb : 2'h3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rstn = 1'b0; flag = 1'b0; clr = 1'b0; flag_b = 1'b0; clr_b = 1'b0;
    #5;
    check("rst_bcd",    32'(bcd_data),   32'h0);
    check("rst_point",  32'(point),      32'h0);
    check("rst_seg_en", 32'(seg_en),     32'h0);
    check("rst_mask",   32'(digit_mask), 32'h3f);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("seg_en_before_edge", 32'(seg_en), 32'h0);
    tick();
    check("seg_en_after_edge", 32'(seg_en),     32'h1);
    check("point_loaded",      32'(point),      32'h04);
    check("bcd_idle",          32'(bcd_data),   32'h0);
    check("mask_idle",         32'(digit_mask), 32'(m6(6'b000001)));
    check("point_b_loaded",    32'(point_b),    32'h1);
    tick();
    check("bcd_hold", 32'(bcd_data), 32'h0);

    // Nine ticks then a single pulse across the 9 -> 10 boundary.
    flag = 1'b1; ticks(9); flag = 1'b0;
    check("bcd_9", 32'(bcd_data), 32'h000009);
    flag = 1'b1; tick(); flag = 1'b0;
    check("bcd_10",      32'(bcd_data),   32'h000010);
    check("mask_10",     32'(digit_mask), 32'(m6(6'b000011)));
    tick();
    check("bcd_10_hold", 32'(bcd_data),   32'h000010);

    // Clear, then flag held for 12 cycles.
    clr = 1'b1; tick(); clr = 1'b0;
    check("bcd_clr", 32'(bcd_data), 32'h0);
    flag = 1'b1; ticks(12); flag = 1'b0;
    check("bcd_12",  32'(bcd_data),   32'h000012);
    check("mask_12", 32'(digit_mask), 32'(m6(6'b000011)));

    // Count to 4567, then flag and clr together must clear.
    clr = 1'b1; tick(); clr = 1'b0;
    flag = 1'b1; ticks(4567); flag = 1'b0;
    check("bcd_4567",  32'(bcd_data),   32'h004567);
    check("mask_4567", 32'(digit_mask), 32'(m6(6'b001111)));
    flag = 1'b1; clr = 1'b1; tick(); flag = 1'b0; clr = 1'b0;
    check("clr_wins",      32'(bcd_data),   32'h0);
    check("clr_wins_mask", 32'(digit_mask), 32'(m6(6'b000001)));

    // 120 -> blanking of the top three digits.
    flag = 1'b1; ticks(120); flag = 1'b0;
    check("bcd_120",  32'(bcd_data),   32'h000120);
    check("mask_120", 32'(digit_mask), 32'(m6(6'b000111)));

    // Two-digit instance: 99 then wrap to 00.
    flag_b = 1'b1; ticks(99); flag_b = 1'b0;
    check("b_bcd_99",  32'(bcd_b),  32'h99);
    check("b_mask_99", 32'(mask_b), 32'(m2(2'b11)));
    flag_b = 1'b1; tick(); flag_b = 1'b0;
    check("b_wrap",      32'(bcd_b),  32'h00);
    check("b_wrap_mask", 32'(mask_b), 32'(m2(2'b01)));
    flag_b = 1'b1; tick(); flag_b = 1'b0;
    check("b_after_wrap", 32'(bcd_b), 32'h01);

    // Reset mid-count with flag high: outputs clear before the next edge.
    flag = 1'b1; ticks(3);
    check("bcd_123", 32'(bcd_data), 32'h000123);
    #4;
    rstn = 1'b0;
    #1;
    check("mid_rst_bcd",    32'(bcd_data),   32'h0);
    check("mid_rst_point",  32'(point),      32'h0);
    check("mid_rst_seg_en", 32'(seg_en),     32'h0);
    check("mid_rst_mask",   32'(digit_mask), 32'h3f);
    check("mid_rst_b_bcd",  32'(bcd_b),      32'h0);
    check("mid_rst_b_mask", 32'(mask_b),     32'h3);
    tick();
    check("rst_held_bcd", 32'(bcd_data), 32'h0);
    flag = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("rerelease_seg_en", 32'(seg_en),   32'h1);
    check("rerelease_bcd",    32'(bcd_data), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
